// File: rtl/neptuno_joyserializer_if.sv
// Serial joystick link between the decoder (master) and the shift-chain emulator (slave).
interface neptuno_joyserializer_if;
  logic joy_clk;   // shift clock from decoder
  logic joy_load;  // parallel load, active low
  logic joy_data;  // serial data back to decoder

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/neptuno_joyserializer.sv
// Target-side emulation of the 74HC165-style chain read by the NeptUNO joystick decoder.
// Two active-low 6-button joysticks are captured while load is low, then shifted out
// MSB first, one bit per synchronized rising edge of the link clock.
module neptuno_joyserializer #(
  parameter int   WIDTH       = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL        = 1'b1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  neptuno_joyserializer_if.slave link,
  input  logic joy1_up_i,
  input  logic joy1_down_i,
  input  logic joy1_left_i,
  input  logic joy1_right_i,
  input  logic joy1_fire1_i,
  input  logic joy1_fire2_i,
  input  logic joy2_up_i,
  input  logic joy2_down_i,
  input  logic joy2_left_i,
  input  logic joy2_right_i,
  input  logic joy2_fire1_i,
  input  logic joy2_fire2_i,
  output logic frame_done_o,
  output logic overrun_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  logic [11:0]            joy_q;
  logic [SYNC_STAGES-1:0] jclk_sync_q;
  logic [SYNC_STAGES-1:0] jload_sync_q;
  logic                   jclk_prev_q;
  state_t                 state_q;
  logic [WIDTH-1:0]       sreg_q;
  logic [CW-1:0]          bit_cnt_q;
  logic                   data_q;
  logic                   done_q;
  logic                   ovr_q;

  logic [WIDTH-1:0]       frame_w;
  logic [WIDTH-1:0]       shifted_w;
  logic                   clk_rise_w;
  logic                   load_low_w;

  // Joystick lines registered once; debounce lives in the decoder.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) joy_q <= '1;
    else joy_q <= {joy2_fire2_i, joy2_fire1_i, joy2_right_i, joy2_left_i, joy2_down_i, joy2_up_i,
                   joy1_fire2_i, joy1_fire1_i, joy1_right_i, joy1_left_i, joy1_down_i, joy1_up_i};
  end

  // Synchronize the async link controls; one extra flop on clk gives the rising edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      jclk_sync_q  <= '0;
      jload_sync_q <= '1;
      jclk_prev_q  <= 1'b0;
    end else begin
      jclk_sync_q  <= {jclk_sync_q[SYNC_STAGES-2:0], link.joy_clk};
      jload_sync_q <= {jload_sync_q[SYNC_STAGES-2:0], link.joy_load};
      jclk_prev_q  <= jclk_sync_q[SYNC_STAGES-1];
    end
  end

  // Load level is taken from the last sync stage so that a clock edge and a load edge
  // that hit the pins together are seen in the same cycle, where load wins.
  assign clk_rise_w = jclk_sync_q[SYNC_STAGES-1] & ~jclk_prev_q;
  assign load_low_w = ~jload_sync_q[SYNC_STAGES-1];

  // Frame word: joystick bits in [11:0], FILL above.
  always_comb begin
    frame_w        = {WIDTH{FILL}};
    frame_w[11:0]  = joy_q;
  end

  assign shifted_w = {sreg_q[WIDTH-2:0], FILL};

  // Chain FSM: transparent load, shift on clock rises, saturate and flag overrun after the frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '1;
      bit_cnt_q <= '0;
      data_q    <= 1'b1;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_low_w) begin
        state_q   <= ST_LOAD;
        sreg_q    <= frame_w;
        data_q    <= frame_w[WIDTH-1];
        bit_cnt_q <= '0;
        ovr_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: state_q <= ST_SHIFT;
          ST_SHIFT: begin
            if (clk_rise_w) begin
              sreg_q    <= shifted_w;
              data_q    <= shifted_w[WIDTH-1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CW'(WIDTH - 1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (clk_rise_w) begin
              sreg_q <= shifted_w;
              data_q <= shifted_w[WIDTH-1];
              ovr_q  <= 1'b1;
            end
          end
          default: ;  // idle after reset: wait for a load pulse
        endcase
      end
    end
  end

  assign link.joy_data = data_q;
  assign frame_done_o  = done_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_neptuno_joyserializer.sv
// Bench for neptuno_joyserializer: directed scenarios plus random frames read back
// the way a decoder would, checked against the frame word built from the joystick values.
module tb_neptuno_joyserializer;
  localparam int W = 16;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic [11:0] js = '1;   // {j2 f2,f1,r,l,d,u, j1 f2,f1,r,l,d,u}
  logic frame_done_o, overrun_o;
  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;

  neptuno_joyserializer_if link();

  neptuno_joyserializer #(.WIDTH(W), .SYNC_STAGES(2), .FILL(1'b1)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .link(link),
    .joy1_up_i(js[0]), .joy1_down_i(js[1]), .joy1_left_i(js[2]),
    .joy1_right_i(js[3]), .joy1_fire1_i(js[4]), .joy1_fire2_i(js[5]),
    .joy2_up_i(js[6]), .joy2_down_i(js[7]), .joy2_left_i(js[8]),
    .joy2_right_i(js[9]), .joy2_fire1_i(js[10]), .joy2_fire2_i(js[11]),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o));

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (frame_done_o === 1'b1) fd_cnt++;

  // Expected frame: filler ones above the 12 joystick bits.
  function automatic logic [W-1:0] model_frame(input logic [11:0] v);
    return {{(W-12){1'b1}}, 12'h000} | {{(W-12){1'b0}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic jclk_pulse();
    link.joy_clk = 1'b1; wait_clks(6);
    link.joy_clk = 1'b0; wait_clks(6);
  endtask

  task automatic load_pulse();
    link.joy_load = 1'b0; wait_clks(6);
    link.joy_load = 1'b1; wait_clks(6);
  endtask

  // Sample MSB after load, then one bit after each of the next W-1 rises, then the W-th rise.
  task automatic read_frame(output logic [W-1:0] w);
    w[W-1] = link.joy_data;
    for (int i = W - 2; i >= 0; i--) begin
      jclk_pulse();
      w[i] = link.joy_data;
    end
    jclk_pulse();
  endtask

  initial begin
    logic [W-1:0] got;
    int base;
    link.joy_clk = 1'b0;
    link.joy_load = 1'b1;
    wait_clks(3);
    check("reset_data", 32'(link.joy_data), 32'd1);
    check("reset_done", 32'(frame_done_o), 32'd0);
    check("reset_ovr", 32'(overrun_o), 32'd0);
    reset_n_i = 1'b1;
    wait_clks(3);

    // j1_up and j1_fire1 pressed
    js = 12'hFEE;
    load_pulse();
    base = fd_cnt;
    read_frame(got);
    check("t2_stream", 32'(got), 32'(model_frame(12'hFEE)));
    check("t2_done_once", fd_cnt - base, 1);
    check("t2_no_ovr", 32'(overrun_o), 32'd0);

    // all pressed, then overrun
    js = 12'h000;
    load_pulse();
    base = fd_cnt;
    read_frame(got);
    check("t3_stream", 32'(got), 32'h0000F000);
    check("t3_done_once", fd_cnt - base, 1);
    jclk_pulse();
    check("t3_ovr_data", 32'(link.joy_data), 32'd1);
    check("t3_ovr_set", 32'(overrun_o), 32'd1);
    check("t3_no_extra_done", fd_cnt - base, 1);
    load_pulse();
    check("t3_ovr_clear", 32'(overrun_o), 32'd0);

    // j2_left changes while load low, then after load high
    js = 12'hFFF;
    link.joy_load = 1'b0; wait_clks(4);
    js[8] = 1'b0; wait_clks(6);
    link.joy_load = 1'b1; wait_clks(6);
    js[8] = 1'b1;
    read_frame(got);
    check("t4_capture", 32'(got), 32'(model_frame(12'hEFF)));

    // clock rise coincident with load fall
    js = 12'($urandom);
    wait_clks(2);
    link.joy_load = 1'b0; link.joy_clk = 1'b1; wait_clks(6);
    link.joy_clk = 1'b0; wait_clks(2);
    link.joy_load = 1'b1; wait_clks(6);
    base = fd_cnt;
    read_frame(got);
    check("t5_stream", 32'(got), 32'(model_frame(js)));
    check("t5_done_once", fd_cnt - base, 1);

    // random frames read back decoder-style
    for (int f = 0; f < 100; f++) begin
      logic [11:0] v;
      v = 12'($urandom);
      js = v;
      load_pulse();
      base = fd_cnt;
      read_frame(got);
      check("rand_stream", 32'(got), 32'(model_frame(v)));
      check("rand_done_once", fd_cnt - base, 1);
    end

    // async reset after overrun
    jclk_pulse();
    check("pre_rst_ovr", 32'(overrun_o), 32'd1);
    @(negedge clk_i); #2 reset_n_i = 1'b0; #1;
    check("t1a_ovr_async", 32'(overrun_o), 32'd0);
    wait_clks(2); reset_n_i = 1'b1; wait_clks(2);

    // async reset mid-shift with a 0 on the data line
    js = 12'h000;
    load_pulse();
    for (int i = 0; i < 5; i++) jclk_pulse();
    check("t1_pre_data", 32'(link.joy_data), 32'd0);
    #2 reset_n_i = 1'b0; #1;
    check("t1_data_async", 32'(link.joy_data), 32'd1);
    check("t1_done_async", 32'(frame_done_o), 32'd0);
    check("t1_ovr_async", 32'(overrun_o), 32'd0);
    wait_clks(2); reset_n_i = 1'b1; wait_clks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
